// File: rtl/vga_grid_pkg.sv
// Shared constants for the VGA cell-grid display: colours, palette, timing.
// Build option VGA_GRID_BORDER_EN adds a 1-pixel frame around the grid.
package vga_grid_pkg;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;

  localparam logic [11:0] BG_RGB     = 12'h124;
  localparam logic [11:0] FG_RGB     = 12'hFC0;
  localparam logic [11:0] BORDER_RGB = 12'h8A8;

  localparam logic [11:0] PALETTE [16] = '{
    12'h000, 12'h00F, 12'h0F0, 12'h0FF,
    12'hF00, 12'hF0F, 12'hFF0, 12'hFFF,
    12'h888, 12'h008, 12'h080, 12'h088,
    12'h800, 12'h808, 12'h880, 12'hCCC
  };

  // Flags carried from the address stage to the colour stage.
  typedef struct packed {
    logic in_grid;
    logic border;
    logic hs;
    logic vs;
  } s1_t;

  localparam s1_t S1_IDLE = '{
    in_grid: 1'b0, border: 1'b0, hs: 1'b1, vs: 1'b1
  };

  function automatic logic [11:0] pal_lookup(
    input logic [3:0] idx
  );
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/vga_grid_display_timing_gen.sv
// Pixel divider, h/v raster counters, raw syncs and frame-start pulse.
// Shared by vga_grid_display; no build options affect this block.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW = $clog2(HT),
  localparam int VW = $clog2(VT)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  output logic          pix_tick_o,
  output logic [HW-1:0] h_o,
  output logic [VW-1:0] v_o,
  output logic          hsync_o,
  output logic          vsync_o,
  output logic          frame_start_o
);

  localparam int DW = $clog2(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HT - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VT - 1);
  localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic          tick;

  assign tick = (div_q == DIV_LAST) && !rst_i;

  // Next-state for divider and raster counters.
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (tick) begin
      h_d = (h_q == H_LAST) ? '0 : h_q + 1'b1;
      if (h_q == H_LAST) begin
        v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
      end
    end
  end

  // Counter registers; reset aborts the current line.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q <= '0;
      h_q   <= '0;
      v_q   <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
    end
  end

  assign pix_tick_o    = tick;
  assign h_o           = h_q;
  assign v_o           = v_q;
  assign hsync_o       = !(h_q >= HS_BEG && h_q < HS_END);
  assign vsync_o       = !(v_q >= VS_BEG && v_q < VS_END);
  assign frame_start_o = tick && (h_q == '0) && (v_q == '0);

endmodule

// File: rtl/vga_grid_display.sv
// Cell-grid VGA renderer: address stage, then palette stage (2 pix_ticks).
// Define VGA_GRID_BORDER_EN to draw a 1-pixel border ring round the grid.
module vga_grid_display
  import vga_grid_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int H_ACTIVE   = H_ACTIVE_D,
  parameter int H_FP       = H_FP_D,
  parameter int H_SYNC     = H_SYNC_D,
  parameter int H_BP       = H_BP_D,
  parameter int V_ACTIVE   = V_ACTIVE_D,
  parameter int V_FP       = V_FP_D,
  parameter int V_SYNC     = V_SYNC_D,
  parameter int V_BP       = V_BP_D,
  parameter int GRID_COLS  = 10,
  parameter int GRID_ROWS  = 20,
  parameter int CELL_SHIFT = 4,
  parameter int ORIGIN_X   = 240,
  parameter int ORIGIN_Y   = 80,
  parameter int CELL_BITS  = 1,
  parameter int ADDR_W     = 9
) (
  input  logic                 FPGA_GlobalClock,
  input  logic                 reset,
  input  logic [CELL_BITS-1:0] cell_data,
  output logic [ADDR_W-1:0]    cell_addr,
  output logic [11:0]          rgb,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start
);

  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int GW = GRID_COLS << CELL_SHIFT;
  localparam int GH = GRID_ROWS << CELL_SHIFT;
  localparam logic [HW-1:0] GX0 = HW'(ORIGIN_X);
  localparam logic [HW-1:0] GX1 = HW'(ORIGIN_X + GW);
  localparam logic [VW-1:0] GY0 = VW'(ORIGIN_Y);
  localparam logic [VW-1:0] GY1 = VW'(ORIGIN_Y + GH);
  localparam logic [HW-1:0] HA  = HW'(H_ACTIVE);
  localparam logic [VW-1:0] VA  = VW'(V_ACTIVE);

  logic          tick;
  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic          hs_raw, vs_raw;

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP),
    .H_SYNC  (H_SYNC),   .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP),
    .V_SYNC  (V_SYNC),   .V_BP(V_BP)
  ) u_timing (
    .clk_i        (FPGA_GlobalClock),
    .rst_i        (reset),
    .pix_tick_o   (tick),
    .h_o          (h),
    .v_o          (v),
    .hsync_o      (hs_raw),
    .vsync_o      (vs_raw),
    .frame_start_o(frame_start)
  );

  logic              active, in_grid, border;
  logic [HW-1:0]     col;
  logic [VW-1:0]     row;
  logic [ADDR_W-1:0] addr_d, cell_addr_q;
  s1_t               s1_d, s1_q;
  logic [11:0]       pal_rgb, rgb_d, rgb_q;
  logic              hs_q, vs_q;

  assign active  = (h < HA) && (v < VA);
  assign in_grid = active && (h >= GX0) && (h < GX1)
                 && (v >= GY0) && (v < GY1);
  assign col     = (h - GX0) >> CELL_SHIFT;
  assign row     = (v - GY0) >> CELL_SHIFT;
  assign addr_d  = ADDR_W'(row) * ADDR_W'(GRID_COLS)
                 + ADDR_W'(col);

`ifdef VGA_GRID_BORDER_EN
  // Ring one pixel outside the grid rectangle, clipped to the active area.
  always_comb begin
    border = active && !in_grid
      && (int'(h) >= ORIGIN_X - 1) && (int'(h) <= ORIGIN_X + GW)
      && (int'(v) >= ORIGIN_Y - 1) && (int'(v) <= ORIGIN_Y + GH);
  end
`else
  assign border = 1'b0;
`endif

  // Flags for the pixel whose address is being registered.
  always_comb begin
    s1_d         = S1_IDLE;
    s1_d.in_grid = in_grid;
    s1_d.border  = border;
    s1_d.hs      = hs_raw;
    s1_d.vs      = vs_raw;
  end

  // Stage 1: latch the cell address; it holds while outside the grid.
  always_ff @(posedge FPGA_GlobalClock) begin
    if (reset) begin
      cell_addr_q <= '0;
      s1_q        <= S1_IDLE;
    end else if (tick) begin
      if (in_grid) begin
        cell_addr_q <= addr_d;
      end
      s1_q <= s1_d;
    end
  end

  if (CELL_BITS == 1) begin : g_pal1
    assign pal_rgb = cell_data[0] ? FG_RGB : BG_RGB;
  end else begin : g_paln
    assign pal_rgb = pal_lookup(4'(cell_data));
  end

  // Colour select for the pixel held in stage 1.
  always_comb begin
    rgb_d = 12'h000;
    unique case (1'b1)
      s1_q.in_grid: rgb_d = pal_rgb;
      s1_q.border:  rgb_d = BORDER_RGB;
      default:      rgb_d = 12'h000;
    endcase
  end

  // Stage 2: register colour and the matching delayed syncs.
  always_ff @(posedge FPGA_GlobalClock) begin
    if (reset) begin
      rgb_q <= 12'h000;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (tick) begin
      rgb_q <= rgb_d;
      hs_q  <= s1_q.hs;
      vs_q  <= s1_q.vs;
    end
  end

  assign cell_addr = cell_addr_q;
  assign rgb       = rgb_q;
  assign hsync     = hs_q;
  assign vsync     = vs_q;

endmodule

// File: tb/tb_vga_grid_display.sv
// Bench for vga_grid_display: small raster, 1-bit and 4-bit cell builds,
// checked every clock against a pixel-index reference model.
module tb_vga_grid_display;

  localparam int CD = 2;
  localparam int HA = 40, HF = 2, HS = 4, HB = 2;
  localparam int VA = 30, VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int GC = 4, GR = 3, CS = 2;
  localparam int OX = 8, OY = 6, AW = 4;
  localparam int FRAME = HT * VT * CD;

  localparam logic [11:0] BG  = 12'h124;
  localparam logic [11:0] FG  = 12'hFC0;
  localparam logic [11:0] BRD = 12'h8A8;
  localparam logic [11:0] PAL [16] = '{
    12'h000, 12'h00F, 12'h0F0, 12'h0FF,
    12'hF00, 12'hF0F, 12'hFF0, 12'hFFF,
    12'h888, 12'h008, 12'h080, 12'h088,
    12'h800, 12'h808, 12'h880, 12'hCCC
  };

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [0:0]    d1;
  logic [3:0]    d4;
  logic [AW-1:0] a1, a4;
  logic [11:0]   rgb1, rgb4;
  logic hs1, vs1, fs1, hs4, vs4, fs4;
  logic       mem1 [16];
  logic [3:0] mem4 [16];

  assign d1 = mem1[a1];
  assign d4 = mem4[a4];

  always #5 clk = ~clk;

  vga_grid_display #(
    .CLK_DIV(CD),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .GRID_COLS(GC), .GRID_ROWS(GR), .CELL_SHIFT(CS),
    .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .CELL_BITS(1), .ADDR_W(AW)
  ) dut1 (
    .FPGA_GlobalClock(clk), .reset(reset),
    .cell_data(d1), .cell_addr(a1), .rgb(rgb1),
    .hsync(hs1), .vsync(vs1), .frame_start(fs1)
  );

  vga_grid_display #(
    .CLK_DIV(CD),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .GRID_COLS(GC), .GRID_ROWS(GR), .CELL_SHIFT(CS),
    .ORIGIN_X(OX), .ORIGIN_Y(OY),
    .CELL_BITS(4), .ADDR_W(AW)
  ) dut4 (
    .FPGA_GlobalClock(clk), .reset(reset),
    .cell_data(d4), .cell_addr(a4), .rgb(rgb4),
    .hsync(hs4), .vsync(vs4), .frame_start(fs4)
  );

  // c = clock edges seen with reset low since the last reset edge.
  int   c = 0;
  logic rst_q;
  always @(posedge clk) begin
    c     <= reset ? 0 : c + 1;
    rst_q <= reset;
  end

  int passed = 0;
  int total  = 0;

  function automatic int px_h(input int j);
    return j % HT;
  endfunction

  function automatic int px_v(input int j);
    return (j / HT) % VT;
  endfunction

  function automatic bit grid_at(input int j);
    int h, v;
    h = px_h(j);
    v = px_v(j);
    return h < HA && v < VA
      && h >= OX && h < OX + GC * (1 << CS)
      && v >= OY && v < OY + GR * (1 << CS);
  endfunction

  function automatic int addr_at(input int j);
    return ((px_v(j) - OY) / (1 << CS)) * GC
         + (px_h(j) - OX) / (1 << CS);
  endfunction

  function automatic bit ring_at(input int j);
    int h, v;
    h = px_h(j);
    v = px_v(j);
`ifdef VGA_GRID_BORDER_EN
    return h < HA && v < VA && !grid_at(j)
      && h >= OX - 1 && h <= OX + GC * (1 << CS)
      && v >= OY - 1 && v <= OY + GR * (1 << CS);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [11:0] rgb_at(input int j, input bit wide);
    int a;
    if (grid_at(j)) begin
      a = addr_at(j);
      if (wide) return PAL[mem4[a]];
      return mem1[a] ? FG : BG;
    end
    if (ring_at(j)) return BRD;
    return 12'h000;
  endfunction

  // Latest in-grid pixel among the first k pixels decides cell_addr.
  function automatic int addr_after(input int k);
    for (int j = k - 1; j >= 0; j--) begin
      if (grid_at(j)) return addr_at(j);
    end
    return 0;
  endfunction

  function automatic bit sync_at(input int p, input int a, input int f,
                                 input int s);
    return !(p >= a + f && p < a + f + s);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h (c=%0d)", tag, obs, exp, c);
  endtask

  task automatic check_cycle();
    int k;
    logic [11:0] e_rgb1, e_rgb4;
    logic e_hs, e_vs, e_fs;
    int e_addr;
    if (rst_q) begin
      e_rgb1 = 12'h000; e_rgb4 = 12'h000;
      e_hs = 1'b1; e_vs = 1'b1; e_fs = 1'b0; e_addr = 0;
    end else begin
      k = c / CD;
      e_fs = ((c + 1) % CD == 0) && px_h(k) == 0 && px_v(k) == 0;
      e_addr = addr_after(k);
      if (k < 2) begin
        e_rgb1 = 12'h000; e_rgb4 = 12'h000;
        e_hs = 1'b1; e_vs = 1'b1;
      end else begin
        e_rgb1 = rgb_at(k - 2, 1'b0);
        e_rgb4 = rgb_at(k - 2, 1'b1);
        e_hs = sync_at(px_h(k - 2), HA, HF, HS);
        e_vs = sync_at(px_v(k - 2), VA, VF, VS);
      end
    end
    chk("rgb1", 32'(rgb1), 32'(e_rgb1));
    chk("rgb4", 32'(rgb4), 32'(e_rgb4));
    chk("addr1", 32'(a1), 32'(e_addr));
    chk("addr4", 32'(a4), 32'(e_addr));
    chk("hsync1", 32'(hs1), 32'(e_hs));
    chk("vsync1", 32'(vs1), 32'(e_vs));
    chk("hsync4", 32'(hs4), 32'(e_hs));
    chk("vsync4", 32'(vs4), 32'(e_vs));
    chk("fstart1", 32'(fs1), 32'(e_fs));
    chk("fstart4", 32'(fs4), 32'(e_fs));
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      check_cycle();
    end
  endtask

  initial begin
    // Frame 1: random cells, both data values forced present.
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 1'($urandom);
      mem4[i] = 4'(i);
    end
    mem1[0] = 1'b0;
    mem1[1] = 1'b1;
    reset = 1'b1;
    run(3);
    #1 reset = 1'b0;
    run(FRAME + 40);
    // Mid-frame reset, then a random-pattern frame.
    run($urandom_range(200, 2000));
    #1 reset = 1'b1;
    run(2);
    for (int i = 0; i < 16; i++) begin
      mem1[i] = 1'($urandom);
      mem4[i] = 4'($urandom);
    end
    #1 reset = 1'b0;
    run(FRAME + 40);
    // Third frame completes the 4-bit palette sweep (values 12..15).
    #1 reset = 1'b1;
    run(2);
    for (int i = 0; i < 16; i++) begin
      mem1[i] = ~mem1[i];
      mem4[i] = 4'(i + 4);
    end
    #1 reset = 1'b0;
    run(FRAME + 40);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
